// File: rtl/dmem_lsu_ctrl_if.sv
// dmem_lsu_ctrl_if: core-side load/store request and response bus
interface dmem_lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  modport master (output req_valid, req_we, req_funct3, req_addr, req_wdata,
                  input req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave (input req_valid, req_we, req_funct3, req_addr, req_wdata,
                 output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/dmem_lsu_ctrl.sv
// dmem_lsu_ctrl: load/store unit with sub-word read-modify-write; DMEM_MISALIGN_TRAP_EN enables misalignment trapping
module dmem_lsu_ctrl #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_lsu_ctrl_if.slave    bus,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state, state_nxt;
  logic              we_q, err_q, mis;
  logic [2:0]        f3_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q, data_q, b_sh, h_sh, ld;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis = bus.req_funct3[1] ? |bus.req_addr[1:0] : bus.req_funct3[0] & bus.req_addr[0];
`else
  assign mis = 1'b0;
`endif
  // state register, request latch and read-data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.req_valid) begin
        we_q    <= bus.req_we;
        err_q   <= mis;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr[ADDR_W+1:0];
        wdata_q <= bus.req_wdata;
      end
      if (state == READ) data_q <= mem_rdata;
    end
  end
  // next state: word stores skip the read, sub-word stores read then write
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = mis ? RESP : (bus.req_we && bus.req_funct3[1]) ? WRITE : READ;
      READ:    state_nxt = we_q ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end
  // merge store data into the captured word, byte lanes chosen by width and address
  always_comb begin
    mem_wdata = data_q;
    for (int i = 0; i < 4; i++)
      if (f3_q[1] || (f3_q[0] ? (i[1] == addr_q[1]) : (i[1:0] == addr_q[1:0])))
        mem_wdata[8*i+:8] = f3_q[1] ? wdata_q[8*i+:8] : f3_q[0] ? wdata_q[8*(i%2)+:8] : wdata_q[7:0];
  end
  // load lane select and sign/zero extension
  always_comb begin
    b_sh = data_q >> {addr_q[1:0], 3'b000};
    h_sh = data_q >> {addr_q[1], 4'b0000};
    ld   = f3_q[1] ? data_q
         : f3_q[0] ? {{16{~f3_q[2] & h_sh[15]}}, h_sh[15:0]}
         : {{24{~f3_q[2] & b_sh[7]}}, b_sh[7:0]};
  end
  assign bus.req_ready = state == IDLE;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_err   = state == RESP && err_q;
  assign bus.rsp_rdata = (state == RESP && !we_q && !err_q) ? ld : 32'd0;
  assign mem_we        = state == WRITE;
  assign mem_addr      = addr_q[ADDR_W+1:2];
endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// tb_dmem_lsu_ctrl: directed vectors, reset-abort sequence and randomized checks against a byte-level memory model
module tb_dmem_lsu_ctrl;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] mem [0:16383];
  logic [31:0] sh_mem [0:16383];
  logic        pre_en = 1'b0;
  logic [13:0] pre_idx = '0;
  logic [31:0] pre_val = '0;
  int          n_pass = 0, n_tot = 0;

  dmem_lsu_ctrl_if bus ();
  dmem_lsu_ctrl #(.ADDR_W(14)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk)
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (pre_en) mem[pre_idx] <= pre_val;

  typedef struct {
    bit pre; int pidx; logic [31:0] pval;
    bit we; logic [2:0] f3; logic [31:0] addr, wdata;
    logic [31:0] rd; bit err; int lat; int nwe; int wcyc; logic [31:0] ww; logic [13:0] ma;
  } vec_t;
  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx[13:0]; pre_val = v;
    @(posedge clk); #1;
    pre_en = 1'b0;
    sh_mem[idx] = v;
  endtask

  task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] e_rd, output bit e_err, output int e_lat, output int e_nwe,
                       output logic [31:0] e_ww, output logic [13:0] e_ma);
    int size, off, base, idx;
    logic [31:0] w;
    longint unsigned v;
    size = f3[1] ? 4 : f3[0] ? 2 : 1;
    off = int'(a % 4);
    base = off - off % size;
    idx = int'((a / 4) % 16384);
    w = sh_mem[idx];
    e_ma = idx[13:0];
    e_err = TRAP && (a % size != 0);
    e_rd = 0; e_ww = 0; e_nwe = 0;
    if (e_err) e_lat = 1;
    else if (!we) begin
      v = ({32'd0, w} >> (8 * base)) & ((64'd1 << (8 * size)) - 1);
      if (!f3[2] && size < 4 && v[8*size-1]) v = v - (64'd1 << (8 * size));
      e_rd = v[31:0];
      e_lat = 2;
    end else begin
      for (int b = 0; b < size; b++) w[8*(base+b)+:8] = wd[8*b+:8];
      sh_mem[idx] = w;
      e_ww = w;
      e_nwe = 1;
      e_lat = size == 4 ? 2 : 3;
    end
  endtask

  task automatic run_req(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic err, output int nwe,
                         output int wcyc, output logic [31:0] ww, output logic [13:0] ma);
    lat = 0; rd = 'x; err = 'x; nwe = 0; wcyc = 0; ww = 0; ma = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = wd;
    chk("req_ready_before_accept", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (mem_we) begin nwe++; wcyc = k; ww = mem_wdata; ma = mem_addr; end
      if (bus.rsp_valid) begin lat = k; rd = bus.rsp_rdata; err = bus.rsp_err; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk("rsp_valid_one_cycle", {31'd0, bus.rsp_valid}, 32'd0);
    chk("ready_after_resp", {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    int lat, nwe, wcyc, e_lat, e_nwe, rsp_seen;
    logic [31:0] rd, ww, e_rd, e_ww, a, wd;
    logic err, e_err, we;
    logic [13:0] ma, e_ma;
    logic [2:0] f3;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0; bus.req_addr = '0; bus.req_wdata = '0;
    vecs[0]  = '{1, 5, 32'h11223344, 0, 3'b000, 32'h17, 32'h0, 32'h00000011, 0, 2, 0, 0, 32'h0, 14'h0};
    vecs[1]  = '{1, 5, 32'h000080FF, 0, 3'b001, 32'h14, 32'h0, 32'hFFFF80FF, 0, 2, 0, 0, 32'h0, 14'h0};
    vecs[2]  = '{0, 0, 32'h0,        0, 3'b101, 32'h14, 32'h0, 32'h000080FF, 0, 2, 0, 0, 32'h0, 14'h0};
    vecs[3]  = '{1, 2, 32'hAABBCCDD, 1, 3'b000, 32'h09, 32'h5A, 32'h0, 0, 3, 1, 2, 32'hAABB5ADD, 14'h2};
    vecs[4]  = '{0, 0, 32'h0, 1, 3'b010, 32'h40, 32'hDEADBEEF, 32'h0, 0, 2, 1, 1, 32'hDEADBEEF, 14'h10};
    vecs[5]  = '{0, 0, 32'h0, 0, 3'b010, 32'h40, 32'h0, 32'hDEADBEEF, 0, 2, 0, 0, 32'h0, 14'h0};
`ifdef DMEM_MISALIGN_TRAP_EN
    vecs[6]  = '{0, 0, 32'h0, 0, 3'b010, 32'h42, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0, 14'h0};
`else
    vecs[6]  = '{0, 0, 32'h0, 0, 3'b010, 32'h42, 32'h0, 32'hDEADBEEF, 0, 2, 0, 0, 32'h0, 14'h0};
`endif
    vecs[7]  = '{1, 3, 32'h01234567, 1, 3'b001, 32'h0E, 32'h0000BEEF, 32'h0, 0, 3, 1, 2, 32'hBEEF4567, 14'h3};
    vecs[8]  = '{0, 0, 32'h0, 0, 3'b101, 32'h0E, 32'h0, 32'h0000BEEF, 0, 2, 0, 0, 32'h0, 14'h0};
    vecs[9]  = '{0, 0, 32'h0, 0, 3'b000, 32'h0F, 32'h0, 32'hFFFFFFBE, 0, 2, 0, 0, 32'h0, 14'h0};
    vecs[10] = '{0, 0, 32'h0, 0, 3'b100, 32'h0C, 32'h0, 32'h00000067, 0, 2, 0, 0, 32'h0, 14'h0};
    vecs[11] = '{0, 0, 32'h0, 0, 3'b011, 32'h0C, 32'h0, 32'hBEEF4567, 0, 2, 0, 0, 32'h0, 14'h0};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset_mem_addr", {18'd0, mem_addr}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 32; i++) preload(i, $urandom);
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].pre) preload(vecs[i].pidx, vecs[i].pval);
      model(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, e_rd, e_err, e_lat, e_nwe, e_ww, e_ma);
      run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, rd, err, nwe, wcyc, ww, ma);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
      chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].err});
      chk($sformatf("vec%0d_write_count", i), nwe, vecs[i].nwe);
      if (vecs[i].nwe == 1) begin
        chk($sformatf("vec%0d_write_cycle", i), wcyc, vecs[i].wcyc);
        chk($sformatf("vec%0d_mem_wdata", i), ww, vecs[i].ww);
        chk($sformatf("vec%0d_mem_addr", i), {18'd0, ma}, {18'd0, vecs[i].ma});
      end
    end
    preload(7, 32'h55667788);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b001; bus.req_addr = 32'h1C; bus.req_wdata = 32'h1234;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_we_in_write", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_we_async_drop", {31'd0, mem_we}, 32'd0);
    chk("abort_idle", {31'd0, bus.req_ready}, 32'd1);
    chk("abort_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    rsp_seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) rsp_seen++;
    end
    chk("abort_no_late_rsp", rsp_seen, 0);
    run_req(1'b0, 3'b010, 32'h1C, 32'h0, lat, rd, err, nwe, wcyc, ww, ma);
    chk("abort_word_unchanged", rd, 32'h55667788);
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a = $urandom_range(0, 127);
      wd = $urandom;
      model(we, f3, a, wd, e_rd, e_err, e_lat, e_nwe, e_ww, e_ma);
      run_req(we, f3, a, wd, lat, rd, err, nwe, wcyc, ww, ma);
      chk($sformatf("rnd%0d_latency", i), lat, e_lat);
      chk($sformatf("rnd%0d_rdata", i), rd, e_rd);
      chk($sformatf("rnd%0d_err", i), {31'd0, err}, {31'd0, e_err});
      chk($sformatf("rnd%0d_write_count", i), nwe, e_nwe);
      if (e_nwe == 1) begin
        chk($sformatf("rnd%0d_write_cycle", i), wcyc, e_lat - 1);
        chk($sformatf("rnd%0d_mem_wdata", i), ww, e_ww);
        chk($sformatf("rnd%0d_mem_addr", i), {18'd0, ma}, {18'd0, e_ma});
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
